convert_3x32_to_48: RTL and testbench
=====================================

Name: convert_3x32_to_48

Overview:
- Gearbox for the CSA return/loopback path: packs a stream of 32-bit words into 48-bit words (3 in -> 2 out).
- Reads from the 32-bit FIFO read side in the same ren/rdata/r_ready style as the 32->40 input converter.
- Writes into the 48-bit CSA-width FIFO write side.
- It is the inverse of the 48 -> 3x32 splitter on the output path: feeding its 32-bit words back through this block restores the original 48-bit words.

Parameters:
- BYTE_WIDTH, 8, bits per byte.
- IN_DATA_WIDTH_BY_BYTE, 4, input word bytes; only 4 is legal.
- OUT_DATA_WIDTH_BY_BYTE, 6, output word bytes; only 6 is legal.
- COUNT_WIDTH, 16, width of the output-word counter.

Ports:
- clk  in  1  single clock for both sides.
- rst_n  in  1  asynchronous, active-low reset.
- in_r_ready  in  1  upstream FIFO holds at least one word.
- in_rclk  out  1  equals clk.
- in_ren  out  1  read strobe; data returns one cycle later.
- in_rdata  in  32  read data, valid the cycle after in_ren.
- out_error_full  in  1  downstream FIFO full.
- out_wclk  out  1  equals clk.
- out_wen  out  1  write strobe.
- out_wdata  out  48  write data.
- phase  out  2  index (0..2) of the next input word within its 3-word group.
- out_count  out  COUNT_WIDTH  number of 48-bit words written; wraps.

Behaviour:
- Reset (async assert, sync release) clears:
  - rd_inflight, hold_valid, out_hold, residue, phase and out_count all to 0.
  - As a result, in_ren=0, out_wen=0, out_wdata=0.
- Read issue:
  - in_ren = in_r_ready & ~rd_inflight & ~hold_valid. Combinational from registers and the input.
  - When in_ren=1, rd_inflight<=1 for exactly one cycle.
  - At most one read is outstanding.
- Data capture happens in the cycle where rd_inflight=1 (in_rdata valid):
  - phase 0: residue[31:0]<=in_rdata; phase<=1; no output.
  - phase 1: out_hold<={residue[31:0], in_rdata[31:16]}; residue[15:0]<=in_rdata[15:0]; hold_valid<=1; phase<=2.
  - phase 2: out_hold<={residue[15:0], in_rdata[31:0]}; hold_valid<=1; phase<=0.
- Byte order: the first byte received occupies out_wdata[47:40].
- Output write:
  - out_wen = hold_valid & ~out_error_full. Combinational.
  - out_wdata = out_hold.
  - When out_wen=1: hold_valid<=0 and out_count<=out_count+1 (wraps modulo 2^COUNT_WIDTH).
  - While out_error_full=1, out_hold is kept unchanged and no reads are issued (back-pressure).
- Latency: the last contributing in_ren to out_wen is 2 cycles, absent full.
- Throughput, unstalled: one read per 2 cycles in phase 0. A read completing phase 1 or 2 causes a 3-cycle spacing to the next read.
- Boundaries:
  - in_r_ready dropping while rd_inflight=1: the in-flight data is still captured.
  - A partial group (phase 1 or 2) simply waits indefinitely; there is no timeout and no padding.
  - out_error_full asserted exactly on the capture cycle: the capture still happens, and out_wen stays 0 until full clears.
  - Reset mid-group discards residue and out_hold. The next word after reset is treated as phase 0.
- Forbidden states:
  - hold_valid=1 together with rd_inflight=1 is unreachable.
  - in_ren must never be asserted while hold_valid=1.

Test Plan:
- Basic pack: feed 0x00112233, 0x44556677, 0x8899AABB -> out_wdata 0x001122334455 then 0x66778899AABB; out_count=2; phase=0.
- Continuous stream of 30 words with in_r_ready held high -> exactly 20 writes in order, no drops. Spacing between reads is 2 or 3 cycles as specified.
- Back-pressure:
  - Assert out_error_full for 10 cycles around the second output.
  - Required: out_wdata held at 0x66778899AABB and in_ren=0 throughout.
  - Required: one write occurs the cycle after full deasserts.
- Starvation: deliver 0xDEADBEEF, drop in_r_ready for 20 cycles, then 0xCAFEF00D -> single write 0xDEADBEEFCAFE issued 2 cycles after the second in_ren; phase=2.
- Reset mid-group: reset after word 0xAAAAAAAA (phase=1), then feed 0x00112233, 0x44556677 -> out_wdata 0x001122334455; 0xAAAA never appears.
- Counter wrap: with COUNT_WIDTH=4, 17 outputs -> out_count reads 1.

Source files
------------

// File: rtl/convert_3x32_to_48_if.sv
// rtl/convert_3x32_to_48_if.sv - read/write bundle between the 32-bit FIFO, the gearbox and the 48-bit FIFO
//
// Purpose: groups the upstream FIFO read side and the downstream FIFO write side
// of the 3x32 -> 48 gearbox into one connection.
//
// Signals:
//   in_r_ready      upstream FIFO holds at least one word
//   in_ren          read strobe towards the upstream FIFO
//   in_rdata        read data, valid the cycle after in_ren
//   out_error_full  downstream FIFO full
//   out_wen         write strobe towards the downstream FIFO
//   out_wdata       write data
//
// Modports:
//   slave   the gearbox view (drives in_ren, out_wen, out_wdata)
//   master  the FIFO/environment view (drives in_r_ready, in_rdata, out_error_full)

interface convert_3x32_to_48_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 48
);
   logic             in_r_ready;
   logic             in_ren;
   logic [IN_W-1:0]  in_rdata;
   logic             out_error_full;
   logic             out_wen;
   logic [OUT_W-1:0] out_wdata;

   modport slave (
      input  in_r_ready,
      input  in_rdata,
      input  out_error_full,
      output in_ren,
      output out_wen,
      output out_wdata
   );

   modport master (
      output in_r_ready,
      output in_rdata,
      output out_error_full,
      input  in_ren,
      input  out_wen,
      input  out_wdata
   );
endinterface

// File: rtl/convert_3x32_to_48.sv
// rtl/convert_3x32_to_48.sv - gearbox packing three 32-bit words into two 48-bit words
//
// Purpose: return/loopback path gearbox. Reads 32-bit words from a FIFO read
// port (ren / rdata one cycle later) and writes 48-bit words into a FIFO write
// port. The first byte received lands in out_wdata[47:40]; it undoes the
// 48 -> 3x32 splitter used on the output path.
//
// Ports:
//   clk        single clock for both FIFO sides
//   rst_n      asynchronous active-low reset (release synchronised upstream)
//   bus        slave side of convert_3x32_to_48_if (read + write handshakes)
//   in_rclk    read clock, equals clk
//   out_wclk   write clock, equals clk
//   phase      index (0..2) of the next input word within its 3-word group
//   out_count  number of 48-bit words written, wraps

module convert_3x32_to_48 #(
   parameter int BYTE_WIDTH             = 8,
   parameter int IN_DATA_WIDTH_BY_BYTE  = 4,
   parameter int OUT_DATA_WIDTH_BY_BYTE = 6,
   parameter int COUNT_WIDTH            = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   convert_3x32_to_48_if.slave        bus,
   output logic                       in_rclk,
   output logic                       out_wclk,
   output logic [1:0]                 phase,
   output logic [COUNT_WIDTH-1:0]     out_count
);

   localparam int IN_W   = BYTE_WIDTH * IN_DATA_WIDTH_BY_BYTE;
   localparam int OUT_W  = BYTE_WIDTH * OUT_DATA_WIDTH_BY_BYTE;
   localparam int HALF_W = IN_W / 2;

   // Position of the next word to be captured inside its 3-word group.
   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2
   } phase_e;

   phase_e                 phase_q, phase_d;
   logic                   rd_inflight_q, rd_inflight_d;
   logic                   hold_valid_q, hold_valid_d;
   logic [OUT_W-1:0]       out_hold_q, out_hold_d;
   logic [IN_W-1:0]        residue_q, residue_d;
   logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;

   logic                   ren;
   logic                   wen;

   // A new read is only issued once the previous one has landed and the
   // output holding register is empty, so at most one word is ever in flight
   // and a capture can never overwrite an unwritten output word.
   assign ren = bus.in_r_ready & ~rd_inflight_q & ~hold_valid_q;
   assign wen = hold_valid_q & ~bus.out_error_full;

   assign bus.in_ren    = ren;
   assign bus.out_wen   = wen;
   assign bus.out_wdata = out_hold_q;

   assign in_rclk   = clk;
   assign out_wclk  = clk;
   assign phase     = phase_q;
   assign out_count = out_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q       <= PH0;
         rd_inflight_q <= 1'b0;
         hold_valid_q  <= 1'b0;
         out_hold_q    <= '0;
         residue_q     <= '0;
         out_count_q   <= '0;
      end else begin
         phase_q       <= phase_d;
         rd_inflight_q <= rd_inflight_d;
         hold_valid_q  <= hold_valid_d;
         out_hold_q    <= out_hold_d;
         residue_q     <= residue_d;
         out_count_q   <= out_count_d;
      end
   end

   always_comb begin
      phase_d       = phase_q;
      rd_inflight_d = ren;
      hold_valid_d  = hold_valid_q;
      out_hold_d    = out_hold_q;
      residue_d     = residue_q;
      out_count_d   = out_count_q;

      if (wen) begin
         hold_valid_d = 1'b0;
         out_count_d  = out_count_q + COUNT_WIDTH'(1);
      end

      // rdata is valid in the cycle after the read strobe. A capture and a
      // write never coincide because reads are blocked while hold_valid is set.
      if (rd_inflight_q) begin
         case (phase_q)
            PH0: begin
               residue_d = bus.in_rdata;
               phase_d   = PH1;
            end
            PH1: begin
               // Word 0 plus the upper half of word 1; the lower half is kept
               // as the leading 16 bits of the second output word.
               out_hold_d              = {residue_q, bus.in_rdata[IN_W-1:HALF_W]};
               residue_d[HALF_W-1:0]   = bus.in_rdata[HALF_W-1:0];
               hold_valid_d            = 1'b1;
               phase_d                 = PH2;
            end
            PH2: begin
               out_hold_d   = {residue_q[HALF_W-1:0], bus.in_rdata};
               hold_valid_d = 1'b1;
               phase_d      = PH0;
            end
            default: begin
               phase_d = PH0;
            end
         endcase
      end
   end

   // Structural invariants of the handshake.
   a_no_hold_with_inflight : assert property (
      @(posedge clk) disable iff (!rst_n) !(hold_valid_q && rd_inflight_q));

   a_no_read_while_holding : assert property (
      @(posedge clk) disable iff (!rst_n) !(ren && hold_valid_q));

endmodule

// File: tb/tb_convert_3x32_to_48.sv
// tb/tb_convert_3x32_to_48.sv - self-checking bench for the 3x32 -> 48 gearbox

module tb_convert_3x32_to_48;

   localparam int CW = 4;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [47:0] w0;
      logic [47:0] w1;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_rclk;
   logic          out_wclk;
   logic [1:0]    phase;
   logic [CW-1:0] out_count;

   always #5 clk = ~clk;

   convert_3x32_to_48_if bus ();

   convert_3x32_to_48 #(.COUNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .in_rclk   (in_rclk),
      .out_wclk  (out_wclk),
      .phase     (phase),
      .out_count (out_count)
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          writes = 0;
   int          words_rx = 0;
   bit          allow_ready = 1'b1;
   bit          ren_pending = 1'b0;
   logic [31:0] fifo_q[$];
   logic [7:0]  bytes_q[$];
   logic [47:0] exp_q[$];
   logic [47:0] obs_q[$];
   int          ren_cycles[$];
   int          wen_cycles[$];
   vec_t        tbl[5];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: the byte stream of all words read since reset, cut into 6-byte words.
   task automatic model_accept(input logic [31:0] w);
      logic [47:0] o;
      words_rx++;
      for (int b = 3; b >= 0; b--) bytes_q.push_back(w[8*b +: 8]);
      while (bytes_q.size() >= 6) begin
         o = '0;
         for (int k = 0; k < 6; k++) o = {o[39:0], bytes_q.pop_front()};
         exp_q.push_back(o);
      end
   endtask

   // Upstream FIFO responder and output monitor.
   initial begin
      logic [31:0] w;
      bus.in_r_ready = 1'b0;
      bus.in_rdata   = '0;
      forever begin
         @(posedge clk);
         #1;
         if (ren_pending && rst_n && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            bus.in_rdata = w;
            model_accept(w);
         end else begin
            bus.in_rdata = $urandom();
         end
         ren_pending = 1'b0;
         bus.in_r_ready = allow_ready && (fifo_q.size() > 0);
         @(negedge clk);
         if (rst_n) begin
            if (bus.in_ren) begin
               ren_pending = 1'b1;
               ren_cycles.push_back(cyc);
            end
            if (bus.out_wen) begin
               writes++;
               wen_cycles.push_back(cyc);
               obs_q.push_back(bus.out_wdata);
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_write: actual=%h required=none", bus.out_wdata);
               end else begin
                  check("stream_word", bus.out_wdata, exp_q.pop_front());
               end
            end
            if (bus.in_ren && bus.out_wen) begin
               miscompares++;
               $display("FAIL ren_with_hold: actual=1 required=0 (cycle %0d)", cyc);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_writes(input int target, input int budget, input string name);
      int n = 0;
      while (writes < target && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      check(name, writes, target);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      fifo_q.delete();
      bytes_q.delete();
      exp_q.delete();
      obs_q.delete();
      ren_cycles.delete();
      wen_cycles.delete();
      writes   = 0;
      words_rx = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int base;
      bus.out_error_full = 1'b0;

      tbl[0] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 48'h001122334455, 48'h66778899AABB};
      tbl[1] = '{32'h00000000, 32'h00000000, 32'h00000000, 48'h000000000000, 48'h000000000000};
      tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
      tbl[3] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 48'h0123456789AB, 48'hCDEFFEDCBA98};
      tbl[4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0000FFFF, 48'hA5A5A5A55A5A, 48'h5A5A0000FFFF};

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_ren", bus.in_ren, 0);
      check("rst_wen", bus.out_wen, 0);
      check("rst_wdata", bus.out_wdata, 0);
      check("rst_phase", phase, 0);
      check("rst_count", out_count, 0);
      check("rst_rclk", in_rclk, clk);
      check("rst_wclk", out_wclk, clk);

      // Basic pack with latency check
      fifo_q.push_back(32'h00112233);
      fifo_q.push_back(32'h44556677);
      fifo_q.push_back(32'h8899AABB);
      wait_writes(2, 60, "basic_writes");
      idle(2);
      check("basic_w0", obs_q[0], 48'h001122334455);
      check("basic_w1", obs_q[1], 48'h66778899AABB);
      check("basic_count", out_count, 2);
      check("basic_phase", phase, 0);
      check("basic_latency", wen_cycles[1] - ren_cycles[2], 2);

      // Table of packing patterns
      for (int i = 0; i < 5; i++) begin
         base = writes;
         obs_q.delete();
         fifo_q.push_back(tbl[i].a);
         fifo_q.push_back(tbl[i].b);
         fifo_q.push_back(tbl[i].c);
         wait_writes(base + 2, 60, "tbl_writes");
         idle(2);
         check("tbl_w0", obs_q[0], tbl[i].w0);
         check("tbl_w1", obs_q[1], tbl[i].w1);
         check("tbl_phase", phase, words_rx % 3);
      end

      // Continuous random stream: 30 words -> 20 writes, read spacing 2/3
      base = writes;
      ren_cycles.delete();
      for (int i = 0; i < 30; i++) fifo_q.push_back($urandom());
      wait_writes(base + 20, 400, "stream_writes");
      idle(3);
      check("stream_reads", ren_cycles.size(), 30);
      for (int i = 0; i < 29; i++)
         check("stream_spacing", ren_cycles[i+1] - ren_cycles[i], (i % 3 == 0) ? 2 : 3);
      check("stream_drained", exp_q.size(), 0);
      check("stream_count", out_count, writes % 16);

      // Back-pressure around the second output, raised on its capture cycle
      base = writes;
      obs_q.delete();
      fifo_q.push_back(32'h00112233);
      fifo_q.push_back(32'h44556677);
      fifo_q.push_back(32'h8899AABB);
      wait_writes(base + 1, 60, "bp_first");
      @(posedge clk);
      #1;
      bus.out_error_full = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_ren", bus.in_ren, 0);
         check("bp_wen", bus.out_wen, 0);
         if (k >= 1) check("bp_hold", bus.out_wdata, 48'h66778899AABB);
      end
      @(posedge clk);
      #1;
      bus.out_error_full = 1'b0;
      @(negedge clk);
      check("bp_release_wen", bus.out_wen, 1);
      check("bp_release_data", bus.out_wdata, 48'h66778899AABB);
      wait_writes(base + 2, 10, "bp_writes");

      // Starvation mid-group
      idle(2);
      base = writes;
      obs_q.delete();
      fifo_q.push_back(32'hDEADBEEF);
      idle(22);
      check("starve_nowrite", writes, base);
      check("starve_phase1", phase, 1);
      fifo_q.push_back(32'hCAFEF00D);
      wait_writes(base + 1, 40, "starve_write");
      idle(2);
      check("starve_word", obs_q[0], 48'hDEADBEEFCAFE);
      check("starve_latency", wen_cycles[wen_cycles.size()-1] - ren_cycles[ren_cycles.size()-1], 2);
      check("starve_phase2", phase, 2);

      // Reset in the middle of a group
      do_reset();
      fifo_q.push_back(32'hAAAAAAAA);
      idle(6);
      check("mid_phase1", phase, 1);
      do_reset();
      @(negedge clk);
      check("mid_rst_phase", phase, 0);
      check("mid_rst_wdata", bus.out_wdata, 0);
      fifo_q.push_back(32'h00112233);
      fifo_q.push_back(32'h44556677);
      wait_writes(1, 40, "mid_write");
      idle(3);
      check("mid_writes", obs_q.size(), 1);
      check("mid_word", obs_q[0], 48'h001122334455);
      check("mid_phase2", phase, 2);

      // Counter wrap with a 4-bit counter
      do_reset();
      for (int i = 0; i < 26; i++) fifo_q.push_back($urandom());
      wait_writes(17, 400, "wrap_writes");
      idle(4);
      check("wrap_count", out_count, 1);
      check("wrap_phase", phase, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
